// File: rtl/uart_tx_fifo_reader_if.sv
// FIFO-side and serial-side signals of the UART transmitter that drains a TX FIFO.
// master: the transmitter. slave: the FIFO/line side (FIFO model, line monitor).
interface uart_tx_fifo_reader_if #(
  parameter int NB_DATA = 8
);
  logic               i_fifo_empty;
  logic [NB_DATA-1:0] i_fifo_data;
  logic               o_fifo_read;
  logic               o_tx;
  logic               o_tx_busy;
  logic               o_tx_done;

  modport master (
    input  i_fifo_empty,
    input  i_fifo_data,
    output o_fifo_read,
    output o_tx,
    output o_tx_busy,
    output o_tx_done
  );

  modport slave (
    output i_fifo_empty,
    output i_fifo_data,
    input  o_fifo_read,
    input  o_tx,
    input  o_tx_busy,
    input  o_tx_done
  );
endinterface

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops one word from a show-ahead TX FIFO per frame and serialises it LSB first.
// Line and done are registered (one cycle after the deciding edge); the FIFO is only popped from IDLE.
module uart_tx_fifo_reader #(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tick,
  uart_tx_fifo_reader_if.master bus
);

  localparam int CNT_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [CNT_W-1:0] OS_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] SB_LAST  = CNT_W'(SB_TICK - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_DATA - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   tick_cnt, tick_cnt_n;
  logic [IDX_W-1:0]   bit_idx, bit_idx_n;
  logic [NB_DATA-1:0] shreg, shreg_n;
  logic               tx_q, tx_n;
  logic               done_q, done_n;
  logic               pop;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      tx_q     <= tx_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    done_n     = 1'b0;
    pop        = 1'b0;
    tx_n       = 1'b1;

    case (state)
      IDLE: begin
        // FIFO is show-ahead: the head word is captured in the same cycle it is popped
        if (!bus.i_fifo_empty) begin
          pop        = 1'b1;
          shreg_n    = bus.i_fifo_data;
          tick_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = START;
        end
      end
      START: begin
        if (i_tick) begin
          if (tick_cnt == OS_LAST) begin
            tick_cnt_n = '0;
            bit_idx_n  = '0;
            state_n    = DATA;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (tick_cnt == OS_LAST) begin
            tick_cnt_n = '0;
            shreg_n    = shreg >> 1;
            // index parks at the last bit when leaving for STOP, so it never overruns
            if (bit_idx == IDX_LAST) begin
              state_n = STOP;
            end else begin
              bit_idx_n = bit_idx + 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (tick_cnt == SB_LAST) begin
            tick_cnt_n = '0;
            done_n     = 1'b1;
            state_n    = IDLE;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // line level follows the state being entered so the register output never glitches
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  assign bus.o_fifo_read = pop & ~i_reset;
  assign bus.o_tx        = tx_q;
  assign bus.o_tx_busy   = (state != IDLE);
  assign bus.o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader: FIFO models feed two instances (1 and 2 stop bits),
// a tick-sampling line decoder checks each frame against a queue of expected bytes.
module tb_uart_tx_fifo_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic tick;
  int   cyc;
  int   tick_per;
  int   checks;
  int   errors;

  uart_tx_fifo_reader_if #(.NB_DATA(8)) bus0 ();
  uart_tx_fifo_reader_if #(.NB_DATA(8)) bus1 ();

  uart_tx_fifo_reader #(.NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(16)) dut0 (
    .i_clk   (clk),
    .i_reset (rst),
    .i_tick  (tick),
    .bus     (bus0)
  );

  uart_tx_fifo_reader #(.NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(32)) dut1 (
    .i_clk   (clk),
    .i_reset (rst),
    .i_tick  (tick),
    .bus     (bus1)
  );

  logic [7:0] fq0[$];
  logic [7:0] fq1[$];
  logic [7:0] eq0[$];
  logic [7:0] eq1[$];

  logic       s_rd[2], s_tx[2], s_busy[2], s_done[2];
  bit         in_frame[2];
  int         nsmp[2];
  logic       smp[2][0:255];
  int         pop_cyc[2], done_cyc[2], first_tick[2], last_tick[2];
  int         hold_err[2], busy_err[2];
  bit         prev_tick[2];
  logic       prev_tx[2];
  bit         prev_done[2];
  int         ndone[2], npop[2], naborts[2], last_gap[2], last_nticks[2], last_span[2];
  logic [7:0] last_byte[2];
  int         sb_len[2];
  bit         idle_chk;
  int         idle_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus0.i_fifo_empty = (fq0.size() == 0);
    bus0.i_fifo_data  = (fq0.size() > 0) ? fq0[0] : 8'h00;
    bus1.i_fifo_empty = (fq1.size() == 0);
    bus1.i_fifo_data  = (fq1.size() > 0) ? fq1[0] : 8'h00;
    tick = ((cyc % tick_per) == 0);
  endtask

  task automatic push(input int u, input logic [7:0] b);
    if (u == 0) begin
      fq0.push_back(b);
      eq0.push_back(b);
    end else begin
      fq1.push_back(b);
      eq1.push_back(b);
    end
    drive();
  endtask

  task automatic finish_frame(input int u);
    logic [7:0] exp_b;
    logic [7:0] dec;
    int bad_start, bad_bits, bad_stop;
    exp_b = 'x;
    bad_start = 0;
    bad_bits  = 0;
    bad_stop  = 0;
    if (u == 0) begin
      if (eq0.size() > 0) exp_b = eq0.pop_front();
    end else begin
      if (eq1.size() > 0) exp_b = eq1.pop_front();
    end
    chk($sformatf("u%0d_frame_ticks", u), nsmp[u], 144 + sb_len[u]);
    for (int i = 0; i < 16; i++) if (smp[u][i] !== 1'b0) bad_start++;
    for (int k = 0; k < 8; k++) begin
      dec[k] = smp[u][16 + 16*k];
      for (int j = 1; j < 16; j++) if (smp[u][16 + 16*k + j] !== dec[k]) bad_bits++;
    end
    for (int i = 144; i < 144 + sb_len[u]; i++) if (smp[u][i] !== 1'b1) bad_stop++;
    chk($sformatf("u%0d_start_low", u), bad_start, 0);
    chk($sformatf("u%0d_bits_stable", u), bad_bits, 0);
    chk($sformatf("u%0d_stop_high", u), bad_stop, 0);
    chk($sformatf("u%0d_byte", u), dec, exp_b);
    chk($sformatf("u%0d_done_after_last_tick", u), done_cyc[u], last_tick[u] + 1);
    last_byte[u]   = dec;
    last_nticks[u] = nsmp[u];
    last_span[u]   = last_tick[u] - first_tick[u] + tick_per;
    ndone[u]++;
  endtask

  task automatic monitor(input int u, input logic rd, input logic tx, input logic busy, input logic done);
    logic [7:0] dummy;
    if (rst) begin
      if (in_frame[u]) begin
        in_frame[u] = 0;
        naborts[u]++;
        if (u == 0 && eq0.size() > 0) dummy = eq0.pop_front();
        if (u == 1 && eq1.size() > 0) dummy = eq1.pop_front();
      end
      prev_done[u] = 0;
      prev_tick[u] = 0;
      prev_tx[u]   = tx;
      return;
    end
    if (done === 1'b1) begin
      chk($sformatf("u%0d_done_width", u), prev_done[u], 0);
      chk($sformatf("u%0d_done_in_frame", u), in_frame[u], 1);
      if (busy !== 1'b0) busy_err[u]++;
      done_cyc[u] = cyc;
      if (in_frame[u]) begin
        in_frame[u] = 0;
        finish_frame(u);
      end
    end else if (in_frame[u]) begin
      if (busy !== 1'b1) busy_err[u]++;
      // the line may only move after a cycle that carried a tick
      if (cyc > pop_cyc[u] + 1 && !prev_tick[u] && tx !== prev_tx[u]) hold_err[u]++;
      if (tick) begin
        if (nsmp[u] == 0) first_tick[u] = cyc;
        if (nsmp[u] < 256) smp[u][nsmp[u]] = tx;
        nsmp[u]++;
        last_tick[u] = cyc;
      end
    end
    if (rd === 1'b1) begin
      chk($sformatf("u%0d_pop_only_idle", u), in_frame[u], 0);
      in_frame[u] = 1;
      nsmp[u]     = 0;
      for (int i = 0; i < 256; i++) smp[u][i] = 1'bx;
      pop_cyc[u]  = cyc;
      last_gap[u] = cyc - done_cyc[u];
      npop[u]++;
    end
    prev_done[u] = (done === 1'b1);
    prev_tick[u] = tick;
    prev_tx[u]   = tx;
  endtask

  task automatic step();
    logic [7:0] dummy;
    @(negedge clk);
    s_rd[0] = bus0.o_fifo_read; s_tx[0] = bus0.o_tx; s_busy[0] = bus0.o_tx_busy; s_done[0] = bus0.o_tx_done;
    s_rd[1] = bus1.o_fifo_read; s_tx[1] = bus1.o_tx; s_busy[1] = bus1.o_tx_busy; s_done[1] = bus1.o_tx_done;
    monitor(0, s_rd[0], s_tx[0], s_busy[0], s_done[0]);
    monitor(1, s_rd[1], s_tx[1], s_busy[1], s_done[1]);
    if (idle_chk) begin
      for (int u = 0; u < 2; u++)
        if (s_rd[u] !== 1'b0 || s_tx[u] !== 1'b1 || s_busy[u] !== 1'b0) idle_err++;
    end
    @(posedge clk);
    #1;
    if (s_rd[0] === 1'b1 && fq0.size() > 0) dummy = fq0.pop_front();
    if (s_rd[1] === 1'b1 && fq1.size() > 0) dummy = fq1.pop_front();
    cyc++;
    drive();
  endtask

  task automatic wait_frames(input string tag, input int u, input int n, input int bound);
    for (int i = 0; i < bound && ndone[u] < n; i++) step();
    chk(tag, ndone[u], n);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; tick_per = 1; idle_chk = 0; idle_err = 0;
    sb_len[0] = 16; sb_len[1] = 32;
    for (int u = 0; u < 2; u++) begin
      in_frame[u] = 0; nsmp[u] = 0; pop_cyc[u] = -1000; done_cyc[u] = -1000;
      first_tick[u] = 0; last_tick[u] = 0; hold_err[u] = 0; busy_err[u] = 0;
      prev_tick[u] = 0; prev_tx[u] = 1'b1; prev_done[u] = 0;
      ndone[u] = 0; npop[u] = 0; naborts[u] = 0; last_gap[u] = 0;
      last_nticks[u] = 0; last_span[u] = 0; last_byte[u] = 8'h00;
    end
    rst = 1'b1;
    drive();

    // reset with a non-empty FIFO: no pop may leak out while reset is high
    push(0, 8'hA5);
    repeat (3) step();
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d_rst_tx", u), s_tx[u], 1'b1);
      chk($sformatf("u%0d_rst_busy", u), s_busy[u], 1'b0);
      chk($sformatf("u%0d_rst_done", u), s_done[u], 1'b0);
      chk($sformatf("u%0d_rst_read", u), s_rd[u], 1'b0);
    end

    // single 0xA5 frame, tick every cycle
    rst = 1'b0;
    wait_frames("a5_frame_done", 0, 1, 400);
    chk("a5_pops", npop[0], 1);
    chk("a5_byte", last_byte[0], 8'hA5);

    // empty FIFO for 1000 cycles
    idle_chk = 1;
    repeat (1000) step();
    idle_chk = 0;
    chk("empty_idle_violations", idle_err, 0);
    chk("empty_no_pop", npop[0], 1);

    // back-to-back 0x00 then 0xFF
    push(0, 8'h00);
    push(0, 8'hFF);
    wait_frames("b2b_frames_done", 0, 3, 800);
    chk("b2b_pops", npop[0], 3);
    chk("b2b_gap_cycles", last_gap[0], 0);
    chk("b2b_second_byte", last_byte[0], 8'hFF);

    // tick every 4th cycle, byte 0x3C
    tick_per = 4;
    drive();
    push(0, 8'h3C);
    wait_frames("slow_frame_done", 0, 4, 2000);
    chk("slow_span_clocks", last_span[0], 640);
    chk("slow_hold_violations", hold_err[0], 0);
    chk("slow_byte", last_byte[0], 8'h3C);

    // reset during data bit 3, 0x55 waiting behind the aborted byte
    tick_per = 1;
    drive();
    push(0, 8'h33);
    push(0, 8'h55);
    for (int i = 0; i < 300 && !(in_frame[0] && nsmp[0] >= 68); i++) step();
    chk("midrst_reached_bit3", (in_frame[0] && nsmp[0] >= 68), 1'b1);
    rst = 1'b1;
    step();
    chk("midrst_read_in_reset", s_rd[0], 1'b0);
    rst = 1'b0;
    step();
    chk("midrst_tx_after", s_tx[0], 1'b1);
    chk("midrst_done_after", s_done[0], 1'b0);
    chk("midrst_pop_first_cycle", s_rd[0], 1'b1);
    wait_frames("midrst_next_frame_done", 0, 5, 400);
    chk("midrst_aborts", naborts[0], 1);
    chk("midrst_byte", last_byte[0], 8'h55);

    // two stop bits, byte 0x81
    push(1, 8'h81);
    wait_frames("sb32_frame_done", 1, 1, 400);
    chk("sb32_ticks", last_nticks[1], 176);
    chk("sb32_byte", last_byte[1], 8'h81);

    chk("u0_busy_violations", busy_err[0], 0);
    chk("u1_busy_violations", busy_err[1], 0);
    chk("u0_scoreboard_empty", eq0.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_reader.md
UART_TX_FIFO_READER -- requirements
Module: uart_tx_fifo_reader

Interface
REQ-001 Parameter NB_DATA, default 8, meaning data bits per frame (also the FIFO word width).
REQ-002 Parameter OVERSAMPLE, default 16, meaning i_tick strobes per start bit and per data bit.
REQ-003 Parameter SB_TICK, default 16, meaning i_tick strobes in the stop bit (16 = 1 stop bit, 32 = 2 stop bits).
REQ-004 i_clk  input  1  system clock; all state updates on rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_tick  input  1  one-cycle baud-rate strobe at OVERSAMPLE x baud.
REQ-007 i_fifo_empty  input  1  TX FIFO empty flag.
REQ-008 i_fifo_data  input  NB_DATA  TX FIFO head word; valid whenever i_fifo_empty=0; combinational from FIFO, no read latency.
REQ-009 o_fifo_read  output  1  pop strobe to TX FIFO; one cycle per frame.
REQ-010 o_tx  output  1  serial line, idle high, registered.
REQ-011 o_tx_busy  output  1  high while a frame is in START, DATA or STOP.
REQ-012 o_tx_done  output  1  one-cycle pulse at frame completion, registered.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; o_tx_busy = (state != IDLE).
REQ-014 IDLE with i_fifo_empty=0 SHALL assert o_fifo_read combinationally in that cycle, capture i_fifo_data into the shift register, clear the tick counter and enter START on the same edge.
REQ-015 o_fifo_read SHALL be 0 in every state other than IDLE, whenever i_fifo_empty=1, and during any cycle with i_reset=1.
REQ-016 IDLE SHALL ignore i_tick; o_tx=1 in IDLE.
REQ-017 START SHALL drive o_tx=0 and count i_tick; on the tick where the count equals OVERSAMPLE-1, go to DATA with tick count 0 and bit index 0.
REQ-018 DATA SHALL drive o_tx = shift_reg[0] (LSB first); on the tick where the count equals OVERSAMPLE-1, shift right by one, clear count, increment bit index; at bit index NB_DATA-1 go to STOP instead.
REQ-019 STOP SHALL drive o_tx=1; on the tick where the count equals SB_TICK-1, go to IDLE and pulse o_tx_done for exactly one cycle.
REQ-020 The tick counter SHALL be wide enough for max(OVERSAMPLE, SB_TICK)-1 and SHALL advance only on i_tick=1 cycles; cycles without a tick hold all state.
REQ-021 The bit index SHALL be $clog2(NB_DATA) bits wide (minimum 1) and SHALL never exceed NB_DATA-1.
REQ-022 o_tx SHALL be registered from next-state: line transitions appear one cycle after the deciding edge, with no glitches.
REQ-023 Back-to-back: after STOP->IDLE, a non-empty FIFO SHALL be popped in the first IDLE cycle, giving exactly one idle-high cycle between frames.
REQ-024 Frame length SHALL be (1+NB_DATA)*OVERSAMPLE+SB_TICK ticks.
REQ-025 Changes on i_fifo_data or i_fifo_empty after capture SHALL NOT affect the frame in progress.

Reset
REQ-026 i_reset=1 SHALL force state=IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0, o_fifo_read=0, shift register=0, tick count=0, bit index=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame without a done pulse; the popped byte is discarded; the next byte is popped in the first non-reset cycle if the FIFO is non-empty.

Verification
REQ-028 FIFO holds 0xA5, i_tick=1 every cycle, defaults -> one o_fifo_read pulse; o_tx low 16 cycles; bits 1,0,1,0,0,1,0,1 for 16 cycles each; high 16 cycles; o_tx_done pulses once; total 160 ticks.
REQ-029 i_fifo_empty=1 held for 1000 cycles -> o_fifo_read=0, o_tx=1, o_tx_busy=0 throughout.
REQ-030 FIFO holds 0x00 then 0xFF -> two pops; frames separated by exactly one idle cycle; second frame data bits all 1.
REQ-031 i_tick every 4th cycle, byte 0x3C -> frame spans 640 clocks; state holds on non-tick cycles; LSB-first decoding yields 0x3C.
REQ-032 Reset pulsed during DATA bit 3 -> o_tx=1 the next cycle, no o_tx_done; with the FIFO holding 0x55, new frame starts immediately after reset deasserts and decodes as 0x55.
REQ-033 SB_TICK=32 with byte 0x81 -> stop bit high 32 ticks before o_tx_done; total 176 ticks.
